// File: rtl/noc_network_interface.sv
// rtl/noc_network_interface.sv - neuron-core to router local-port network interface
// TX spike packetiser and RX destination filter, each behind its own first-word fall-through FIFO.

module nif_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));
  assign head  = mem[rd_ptr];

  // Callers gate push with !full and pop with !empty, so no overflow guard here.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end
endmodule

module noc_network_interface #(
  parameter int ROUTER_ADDR_WIDTH = 4,
  parameter int TX_DEPTH          = 4,
  parameter int RX_DEPTH          = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ROUTER_ADDR_WIDTH-1:0] router_addr,
  input  logic [ROUTER_ADDR_WIDTH-1:0] core_tx_dest,
  input  logic [15:0]                  core_tx_neuron,
  input  logic                         core_tx_valid,
  output logic                         core_tx_ready,
  output logic [31:0]                  noc_tx_packet,
  output logic                         noc_tx_valid,
  input  logic                         noc_tx_ready,
  input  logic [31:0]                  noc_rx_packet,
  input  logic                         noc_rx_valid,
  output logic                         noc_rx_ready,
  output logic [15:0]                  core_rx_neuron,
  output logic                         core_rx_valid,
  input  logic                         core_rx_ready,
  output logic [7:0]                   rx_misroute_count
);
  logic tx_empty, tx_full, tx_push, tx_pop;
  logic rx_empty, rx_full, rx_push, rx_pop;
  logic rx_accept, rx_addr_match;
  logic [31:0] tx_packet_in;

  // Readies depend only on state and rst, never on the matching valid.
  assign core_tx_ready = !rst && !tx_full;
  assign noc_rx_ready  = !rst && !rx_full;

  assign tx_packet_in = {core_tx_dest, 12'h000, core_tx_neuron};
  assign tx_push      = core_tx_valid && core_tx_ready;
  assign noc_tx_valid = !tx_empty;
  assign tx_pop       = noc_tx_valid && noc_tx_ready;

  nif_fifo #(
    .WIDTH (32),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tx_push),
    .push_data (tx_packet_in),
    .pop       (tx_pop),
    .head      (noc_tx_packet),
    .empty     (tx_empty),
    .full      (tx_full)
  );

  assign rx_accept     = noc_rx_valid && noc_rx_ready;
  assign rx_addr_match = (noc_rx_packet[31:28] == router_addr);
  assign rx_push       = rx_accept && rx_addr_match;
  assign core_rx_valid = !rx_empty;
  assign rx_pop        = core_rx_valid && core_rx_ready;

  nif_fifo #(
    .WIDTH (16),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_push),
    .push_data (noc_rx_packet[15:0]),
    .pop       (rx_pop),
    .head      (core_rx_neuron),
    .empty     (rx_empty),
    .full      (rx_full)
  );

  // Misrouted packets are still consumed from the router so they cannot block the port.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_misroute_count <= 8'h00;
    end else if (rx_accept && !rx_addr_match && (rx_misroute_count != 8'hFF)) begin
      rx_misroute_count <= rx_misroute_count + 8'h01;
    end
  end
endmodule
